// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 master transmitter fed by a valid/ready word stream.
// Ports: clk_100, s_rst_n (sync, active-low), valid/data/ready (input stream),
//        cs_n/sclk/mosi (SPI bus), busy (frame in progress).
// Build option: define SPI_TX_LSB_FIRST_EN to shift bit 0 first (default MSB first).
module spi_master_tx #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CLK_DIV    = 4
) (
    input  logic                    clk_100,
    input  logic                    s_rst_n,
    input  logic                    valid,
    input  logic [P_DATA_WIDTH-1:0] data,
    output logic                    ready,
    output logic                    cs_n,
    output logic                    sclk,
    output logic                    mosi,
    output logic                    busy
);

    localparam int DIV_W = $clog2(P_CLK_DIV);
    localparam int BIT_W = $clog2(P_DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(P_DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(P_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    // Bits still to be sent; the bit on mosi has already left this register.
    logic [P_DATA_WIDTH-2:0] rest;
    logic                    div_end;

    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_100) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            rest    <= '0;
            ready   <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid && ready) begin
                        state   <= SETUP;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
`ifdef SPI_TX_LSB_FIRST_EN
                        mosi    <= data[0];
                        rest    <= data[P_DATA_WIDTH-1:1];
`else
                        mosi    <= data[P_DATA_WIDTH-1];
                        rest    <= data[P_DATA_WIDTH-2:0];
`endif
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                        sclk    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling edge: advance to the next bit, except
                            // after the last one, which holds through HOLD.
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt != BIT_LAST) begin
`ifdef SPI_TX_LSB_FIRST_EN
                                mosi <= rest[0];
                                rest <= rest >> 1;
`else
                                mosi <= rest[P_DATA_WIDTH-2];
                                rest <= rest << 1;
`endif
                            end
                        end else if (bit_cnt == BIT_ALL) begin
                            state <= HOLD;
                        end else begin
                            sclk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        state   <= IDLE;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        mosi    <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bench for spi_master_tx (8-bit words, divider 4).
// Expected mosi bits are queued per word at send time and popped on sclk rises.
module tb_spi_master_tx;

    logic       clk_100 = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       valid   = 1'b0;
    logic [7:0] data    = 8'h00;
    logic       ready;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       busy;

    spi_master_tx #(
        .P_DATA_WIDTH(8),
        .P_CLK_DIV   (4)
    ) dut (
        .clk_100(clk_100),
        .s_rst_n(s_rst_n),
        .valid  (valid),
        .data   (data),
        .ready  (ready),
        .cs_n   (cs_n),
        .sclk   (sclk),
        .mosi   (mosi),
        .busy   (busy)
    );

    always #5 clk_100 = ~clk_100;

    int   checks   = 0;
    int   errors   = 0;
    bit   exp_q[$];
    bit   mon_en   = 1'b0;
    bit   aborting = 1'b0;
    int   rise_cnt = 0;
    int   low_len  = 0;
    int   high_len = 0;
    int   last_gap = 0;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    logic prev_cs_n = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_100) begin
        if (mon_en) begin
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                if (exp_q.size() == 0)
                    chk("unexpected_rise", exp_q.size(), 1);
                else
                    chk("mosi_bit", mosi, exp_q.pop_front());
            end
            if (sclk && prev_sclk)
                chk("mosi_stable_high", mosi, prev_mosi);
            chk("busy_vs_cs_n", busy, !cs_n);
            if (cs_n) begin
                chk("idle_sclk", sclk, 0);
                chk("idle_mosi", mosi, 0);
                if (!prev_cs_n) begin
                    if (!aborting) begin
                        chk("cs_low_len", low_len, 72);
                        chk("rises_per_frame", rise_cnt, 8);
                    end
                    low_len  = 0;
                    rise_cnt = 0;
                    high_len = 0;
                end
                high_len++;
            end else begin
                if (prev_cs_n) begin
                    last_gap = high_len;
                    low_len  = 0;
                end
                low_len++;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            prev_cs_n = cs_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic push_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
`ifdef SPI_TX_LSB_FIRST_EN
            exp_q.push_back(d[i]);
`else
            exp_q.push_back(d[7-i]);
`endif
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(negedge clk_100);
            n++;
        end
        chk(tag, ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        wait_ready("ready_before_send");
        valid = 1'b1;
        data  = d;
        push_word(d);
        @(negedge clk_100);
        chk("accept_cs_n", cs_n, 0);
        chk("accept_ready", ready, 0);
        if (!keep) valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        mon_en = 1'b1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        s_rst_n = 1'b1;
        @(negedge clk_100);
        chk("ready_after_release", ready, 1);

        send(8'hA5, 1'b0);
        wait_ready("a5_done");
        chk("a5_drained", exp_q.size(), 0);

        send(8'h3C, 1'b1);
        send(8'hFF, 1'b0);
        tick(2);
        chk("b2b_gap", last_gap, 1);
        wait_ready("ff_done");
        chk("b2b_drained", exp_q.size(), 0);

        send(8'h81, 1'b1);
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            data = n[0] ? 8'hFF : 8'h00;
            @(negedge clk_100);
            n++;
        end
        chk("toggle_done", ready, 1);
        valid = 1'b0;
        tick(3);
        chk("no_second_accept", cs_n, 1);
        chk("toggle_drained", exp_q.size(), 0);

        send(8'hA5, 1'b0);
        n = 0;
        while (rise_cnt < 3 && n < 1000) begin
            @(negedge clk_100);
            n++;
        end
        chk("abort_rise_cnt", rise_cnt, 3);
        aborting = 1'b1;
        s_rst_n  = 1'b0;
        @(negedge clk_100);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        s_rst_n = 1'b1;

        wait_ready("ready_before_race");
        valid   = 1'b1;
        data    = 8'h77;
        s_rst_n = 1'b0;
        @(negedge clk_100);
        chk("race_cs_n", cs_n, 1);
        chk("race_busy", busy, 0);
        chk("race_ready", ready, 0);
        valid   = 1'b0;
        s_rst_n = 1'b1;
        tick(3);
        chk("race_no_frame", cs_n, 1);
        aborting = 1'b0;

        send(8'h5A, 1'b0);
        wait_ready("5a_done");
        chk("5a_drained", exp_q.size(), 0);

        send(8'h01, 1'b0);
        wait_ready("01_done");
        chk("01_drained", exp_q.size(), 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
